// File: rtl/rsa_pkg.sv
// Shared types and constants for the RSA modular-exponentiation sequencer.
package rsa_pkg;

    localparam int RSA_W      = 8;
    localparam int RED_CYCLES = 2 * RSA_W;
    localparam int MODEXP_LAT = 1 + RED_CYCLES + RSA_W * 2 * RED_CYCLES;

    typedef enum logic [2:0] {
        IDLE,
        BRED,
        SQR,
        MUL,
        FIN
    } rsa_state_e;

    // Operands below 2 leave nothing to reduce into; flagged as an error.
    function automatic logic mod_is_bad(input logic [RSA_W-1:0] n);
        return n < RSA_W'(2);
    endfunction

endpackage

// File: rtl/rsa_modred.sv
// Restoring shift-subtract remainder: one dividend bit per cycle, MSB first.
module rsa_modred
    import rsa_pkg::*;
#(
    parameter int W = RSA_W
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           go_i,
    input  logic [2*W-1:0] dvd_i,
    input  logic [W-1:0]   n_i,
    output logic           rdy_o,
    output logic [W-1:0]   rem_o
);

    localparam int CYC = 2 * W;
    localparam int CW  = $clog2(CYC);

    logic [2*W-1:0] dvd_q;
    logic [W-1:0]   r_q;
    logic [CW-1:0]  cnt_q;
    logic           act_q;
    logic [W:0]     trial;
    logic [W:0]     step;

    // r stays below N, so {r, bit} < 2N and a single subtract restores it.
    always_comb begin
        trial = {r_q, dvd_q[2*W-1]};
        step  = trial;
        if (trial >= {1'b0, n_i}) begin
            step = trial - {1'b0, n_i};
        end
    end

    // rem_o is the result of the step taken on this edge; on the last step
    // it is the final remainder, usable by the caller at the same edge.
    assign rem_o = step[W-1:0];
    assign rdy_o = act_q && (cnt_q == CW'(CYC - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dvd_q <= '0;
            r_q   <= '0;
            cnt_q <= '0;
            act_q <= 1'b0;
        end else if (go_i) begin
            dvd_q <= dvd_i;
            r_q   <= '0;
            cnt_q <= '0;
            act_q <= 1'b1;
        end else if (act_q) begin
            dvd_q <= {dvd_q[2*W-2:0], 1'b0};
            r_q   <= rem_o;
            cnt_q <= cnt_q + CW'(1);
            if (rdy_o) begin
                act_q <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/rsa_modexp_ctrl.sv
// Constant-time left-to-right square-and-multiply: result = base^exp mod modulus.
module rsa_modexp_ctrl
    import rsa_pkg::*;
#(
    parameter int WIDTH = RSA_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] base,
    input  logic [WIDTH-1:0] exp,
    input  logic [WIDTH-1:0] modulus,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [WIDTH-1:0] result
);

    localparam int PW = 2 * WIDTH;
    localparam int BW = $clog2(WIDTH);

    rsa_state_e       state_q;
    logic [WIDTH-1:0] acc_q;
    logic [WIDTH-1:0] base_q;
    logic [WIDTH-1:0] exp_q;
    logic [WIDTH-1:0] mod_q;
    logic [BW-1:0]    bit_q;
    logic             busy_q;
    logic             done_q;
    logic             err_q;
    logic [WIDTH-1:0] res_q;

    logic             red_go;
    logic [PW-1:0]    red_dvd;
    logic             red_rdy;
    logic [WIDTH-1:0] red_rem;
    logic [WIDTH-1:0] mul_acc;
    logic             bad_mod;

    assign bad_mod = (WIDTH == RSA_W) ? mod_is_bad(RSA_W'(modulus)) : (modulus < WIDTH'(2));

    // MUL always runs its full length; the exponent bit only picks what is kept.
    assign mul_acc = exp_q[bit_q] ? red_rem : acc_q;

    // The next product is launched on the same edge the current reduction
    // finishes, so every phase is exactly one reduction long.
    always_comb begin
        red_go  = 1'b0;
        red_dvd = '0;
        case (state_q)
            IDLE: begin
                if (start && !bad_mod) begin
                    red_go  = 1'b1;
                    red_dvd = PW'(base);
                end
            end
            BRED: begin
                if (red_rdy) begin
                    red_go  = 1'b1;
                    red_dvd = PW'(acc_q) * PW'(acc_q);
                end
            end
            SQR: begin
                if (red_rdy) begin
                    red_go  = 1'b1;
                    red_dvd = PW'(red_rem) * PW'(base_q);
                end
            end
            MUL: begin
                if (red_rdy && bit_q != '0) begin
                    red_go  = 1'b1;
                    red_dvd = PW'(mul_acc) * PW'(mul_acc);
                end
            end
            default: ;
        endcase
    end

    rsa_modred #(.W(WIDTH)) u_red (
        .clk   (clk),
        .rst_n (rst_n),
        .go_i  (red_go),
        .dvd_i (red_dvd),
        .n_i   (mod_q),
        .rdy_o (red_rdy),
        .rem_o (red_rem)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            acc_q   <= '0;
            base_q  <= '0;
            exp_q   <= '0;
            mod_q   <= '0;
            bit_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            res_q   <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        base_q <= base;
                        exp_q  <= exp;
                        mod_q  <= modulus;
                        acc_q  <= WIDTH'(1);
                        bit_q  <= BW'(WIDTH - 1);
                        err_q  <= bad_mod;
                        if (bad_mod) begin
                            res_q   <= '0;
                            done_q  <= 1'b1;
                            state_q <= FIN;
                        end else begin
                            busy_q  <= 1'b1;
                            state_q <= BRED;
                        end
                    end
                end
                BRED: begin
                    if (red_rdy) begin
                        base_q  <= red_rem;
                        state_q <= SQR;
                    end
                end
                SQR: begin
                    if (red_rdy) begin
                        acc_q   <= red_rem;
                        state_q <= MUL;
                    end
                end
                MUL: begin
                    if (red_rdy) begin
                        acc_q <= mul_acc;
                        if (bit_q == '0) begin
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                            res_q   <= mul_acc;
                            state_q <= FIN;
                        end else begin
                            bit_q   <= bit_q - BW'(1);
                            state_q <= SQR;
                        end
                    end
                end
                FIN: begin
                    done_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign busy   = busy_q;
    assign done   = done_q;
    assign err    = err_q;
    assign result = res_q;

endmodule

// File: doc/rsa_modexp_ctrl.md
# rsa_modexp_ctrl

Sequencer for modular exponentiation in the 4-bit RSA encoder/decoder. It computes result = base^exp mod modulus on 8-bit operands and serves both encryption (exp = e) and decryption (exp = d). It owns the 8-bit accumulator and base registers, drives their load strobes from a constant-time state machine, and reduces 16-bit products with a shift-subtract remainder unit. It sits between the key/message input registers and the output display register.

## Interface
- `WIDTH`, default 8: operand and result width. Only 8 is verified.
- `clk`  in  1: rising-edge clock.
- `rst_n`  in  1: asynchronous active-low reset.
- `start`  in  1: request. Sampled only in IDLE.
- `base`  in  8: message or ciphertext. Latched on accept.
- `exp`  in  8: exponent. Latched on accept.
- `modulus`  in  8: N = p·q. Latched on accept.
- `busy`  out  1: high while a computation is in progress.
- `done`  out  1: one-cycle pulse when `result` becomes valid.
- `err`  out  1: set with `done` when modulus < 2; cleared on next accept.
- `result`  out  8: last result. Holds its value until the next `done`.

## Operation
- Reset: state = IDLE. `busy`, `done`, `err`, `result` = 0. Internal acc, base_r, exp_r and remainder = 0.
- States: IDLE, BRED, SQR, MUL, FIN.
- **IDLE**
  - On `start` = 1: latch operands and set acc = 1.
  - If modulus < 2: go to FIN with err = 1 and result forced to 0.
  - Otherwise: go to BRED.
- **BRED**: reduce base_r = base mod N. This is a 16-bit dividend with the upper byte zero.
- **Bit loop**: bit index i runs 7 down to 0. All 8 bits are always processed, with no leading-zero skip (constant time).
  - **SQR**: reduce acc·acc mod N, then load acc.
  - **MUL**: reduce acc·base_r mod N. Load acc only if exp_r[i] = 1; otherwise discard the remainder. The state still runs its full length.
  - After MUL at i = 0, go to FIN.
- **FIN**: result = acc (or 0 if err). Pulse `done` for one cycle. Return to IDLE.
- **Reduction**: restoring shift-subtract over the 16-bit product, MSB first, one dividend bit per cycle, 16 cycles.
  - Each cycle: r = {r[7:0], p[k]} (9-bit r). If r ≥ N, then r = r − N.
  - Final r < N, so it fits in 8 bits.
  - Products are formed combinationally (8×8 → 16) and registered on entry to SQR/MUL.
- exp = 0 gives result 1, since N ≥ 2.
- base ≥ N is legal; BRED handles it.
- `start` while busy is ignored. No queueing.
- Operand inputs may change freely after accept.
- `rst_n` low mid-operation: immediate return to IDLE with all outputs 0. No `done` is emitted.

## Timing
- Accept edge = T. `busy` = 1 from T+1 through the end of the bit loop.
- BRED: 16 cycles. Each bit: SQR 16 + MUL 16. Total busy = 16 + 8·32 = 272 cycles.
- FIN at cycle T+273: `done` = 1, `busy` = 0, `result` valid in the same cycle.
- Error path (N < 2): `done`/`err` at T+1. `busy` never asserts.
- Earliest next accept: the cycle after `done`.
- Latency is data-independent. Every valid operand set takes exactly 273 cycles.

## Structure
- Package `rsa_pkg`:
  - state enum (IDLE, BRED, SQR, MUL, FIN)
  - `RSA_W` = 8
  - `RED_CYCLES` = 16
  - `MODEXP_LAT` = 273
- Sub-module `rsa_modred`: 16-bit dividend, 8-bit N, `go`/`rdy` handshake, and a 4-bit cycle counter. Instantiate it once and share it across BRED/SQR/MUL.
- The accumulator and base registers use the same register style as the existing 8-bit load-select register bank.

## Test plan
- N = 143, exp = 7, base = 9 → result = 48, `done` at T+273, err = 0.
- N = 143, exp = 103, base = 48 → result = 9 (decryption round-trip).
- N = 143, exp = 0, base = 200 → result = 1. Then exp = 1, base = 200 → result = 57.
- N = 1, any base/exp → `done` and err = 1 at T+1, result = 0, `busy` never 1. Next valid run clears err.
- `start` pulsed at T+50 during a busy run with different operands → ignored; the original result is produced at T+273.
- `rst_n` asserted at T+100 → outputs 0 immediately, no `done`. New start after release completes correctly in 273 cycles.
